// File: rtl/uart_pkg.sv
// Shared types and helpers for the handshake-driven UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   typedef enum logic {
      HS_WAIT,
      HS_ACK
   } hs_state_t;

   localparam int unsigned FRAME_BITS = 11;

   function automatic logic parity_bit(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding the UART transmitter; DEPTH must be a power of 2.
import uart_pkg::*;

module uart_tx_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_hs.sv
// UART transmitter with four-phase Send/Sent byte intake and 8-data + parity framing.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise a single holding register.
//
// tx state | meaning
// IDLE     | line high, waiting for a buffered byte
// START    | driving start bit (0)
// DATA     | shifting out 8 data bits, LSB first
// PARITY   | driving parity bit
// STOP     | driving stop bit (1); chains straight into the next frame if buffered
import uart_pkg::*;

module uart_tx_hs #(
   parameter int unsigned MAX_CYCLES_COUNT = 5208,
   parameter bit          ODD_PARITY       = 1'b1,
   parameter int unsigned FIFO_DEPTH       = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Send,
   input  logic [7:0] Din,
   output logic       Sent,
   output logic       Sout,
   output logic       busy,
   output logic       full
);

   localparam int unsigned BAUD_W = (MAX_CYCLES_COUNT > 1) ? $clog2(MAX_CYCLES_COUNT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(MAX_CYCLES_COUNT - 1);

   hs_state_t         hs_state;
   tx_state_t         tx_state;
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shift_reg;
   logic              parity_r;
   logic              baud_end;
   logic              push;
   logic              pop;
   logic [7:0]        buf_dout;
   logic              buf_full;
   logic              buf_empty;

   // full is a registered-state flag, so a push is refused when full was set before the edge.
   assign push     = (hs_state == HS_WAIT) && Send && !buf_full;
   assign baud_end = (baud_cnt == BAUD_LAST);
   assign pop      = !buf_empty &&
                     ((tx_state == IDLE) || ((tx_state == STOP) && baud_end));

   assign full = buf_full;
   assign busy = (tx_state != IDLE) || !buf_empty;

`ifdef UART_TX_FIFO_EN
   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (Din),
      .pop   (pop),
      .dout  (buf_dout),
      .full  (buf_full),
      .empty (buf_empty)
   );
`else
   logic       hold_valid;
   logic [7:0] hold_data;
   logic       unused_fifo_depth;

   // Depth only matters for the FIFO build.
   assign unused_fifo_depth = ^FIFO_DEPTH;

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else if (push) begin
         hold_valid <= 1'b1;
         hold_data  <= Din;
      end else if (pop) begin
         hold_valid <= 1'b0;
      end
   end

   assign buf_dout  = hold_data;
   assign buf_full  = hold_valid;
   assign buf_empty = !hold_valid;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         hs_state <= HS_WAIT;
         Sent     <= 1'b0;
      end else begin
         case (hs_state)
            HS_WAIT: begin
               if (push) begin
                  Sent     <= 1'b1;
                  hs_state <= HS_ACK;
               end
            end
            HS_ACK: begin
               if (!Send) begin
                  Sent     <= 1'b0;
                  hs_state <= HS_WAIT;
               end
            end
            default: begin
               Sent     <= 1'b0;
               hs_state <= HS_WAIT;
            end
         endcase
      end
   end

   // Sout is updated on the edge that enters each bit, so every bit lasts exactly one baud period.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state  <= IDLE;
         Sout      <= 1'b1;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         parity_r  <= 1'b0;
      end else if (tx_state == IDLE) begin
         Sout     <= 1'b1;
         baud_cnt <= '0;
         if (pop) begin
            shift_reg <= buf_dout;
            parity_r  <= parity_bit(buf_dout, ODD_PARITY);
            Sout      <= 1'b0;
            tx_state  <= START;
         end
      end else if (!baud_end) begin
         baud_cnt <= baud_cnt + 1'b1;
      end else begin
         baud_cnt <= '0;
         case (tx_state)
            START: begin
               Sout     <= shift_reg[0];
               bit_idx  <= '0;
               tx_state <= DATA;
            end
            DATA: begin
               if (bit_idx == 3'd7) begin
                  Sout     <= parity_r;
                  tx_state <= PARITY;
               end else begin
                  Sout      <= shift_reg[1];
                  shift_reg <= {1'b0, shift_reg[7:1]};
                  bit_idx   <= bit_idx + 3'd1;
               end
            end
            PARITY: begin
               Sout     <= 1'b1;
               tx_state <= STOP;
            end
            STOP: begin
               if (pop) begin
                  shift_reg <= buf_dout;
                  parity_r  <= parity_bit(buf_dout, ODD_PARITY);
                  Sout      <= 1'b0;
                  tx_state  <= START;
               end else begin
                  Sout     <= 1'b1;
                  tx_state <= IDLE;
               end
            end
            default: begin
               Sout     <= 1'b1;
               tx_state <= IDLE;
            end
         endcase
      end
   end

endmodule
